// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI target endpoint:
//   - spi_state_e    : frame engine states (IDLE, LOAD, SHIFT, COMPLETE)
//   - SPI_CPOL/CPHA  : bus mode this target implements (mode 3)
//   - bit_cnt_width  : width of a counter that must reach TOTAL_WIDTH itself
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        SHIFT    = 2'd2,
        COMPLETE = 2'd3
    } spi_state_e;

    // sck idles high; data is driven on the falling edge and sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b1;
    localparam logic SPI_CPHA = 1'b1;

    // The counter has to hold the value TOTAL_WIDTH, hence the +1.
    function automatic int bit_cnt_width(input int total_width);
        return $clog2(total_width + 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchronizer for one asynchronous serial line, followed by a third
// flop used only for edge detection.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   i_async    : raw pin
//   o_sync     : synchronized level (second stage)
//   o_rise     : one-cycle strobe, synchronized level went 0 -> 1
//   o_fall     : one-cycle strobe, synchronized level went 1 -> 0
// Parameter IDLE_VAL is the reset value of every stage, so no edge is
// reported while the line sits at its idle level after reset.
// ---------------------------------------------------------------------------
module spi_sync_edge #(
    parameter logic IDLE_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus the history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= IDLE_VAL;
            r_sync <= IDLE_VAL;
            r_prev <= IDLE_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_target_if.sv
// ---------------------------------------------------------------------------
// spi_target_if
// SPI target (mode CPOL=1/CPHA=1) that oversamples sck/sdo/csn in the clk
// domain, hands received frames to a core over a valid/ready port and shifts
// out response frames taken from a valid/ready port.
// Ports:
//   clk, rst_n           : system clock, asynchronous active-low reset
//   sck, sdo, csn[3:0]   : serial bus from the initiator (csn[CS_INDEX] used)
//   sdi                  : serial data back to the initiator
//   rx_data/valid/ready  : received frame towards the core
//   tx_data/valid        : response frame from the core
//   tx_ready             : pulse, tx_data was taken for a frame
//   busy                 : a frame is being loaded, shifted or completed
//   rx_overrun           : pulse, finished frame dropped (holding reg full)
//   tx_underrun          : pulse, no tx word available, fill word sent
//   frame_abort          : pulse, csn released before the frame finished
// Build option SPI_TGT_LOOPBACK_EN: the fill word on underrun is the last
// word accepted into rx_data instead of TX_IDLE.
// ---------------------------------------------------------------------------
module spi_target_if
    import spi_pkg::*;
#(
    parameter int                     TOTAL_WIDTH = 32,
    parameter int                     CS_INDEX    = 0,
    parameter logic [TOTAL_WIDTH-1:0] TX_IDLE     = {TOTAL_WIDTH{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sck,
    input  logic                   sdo,
    input  logic [3:0]             csn,
    output logic                   sdi,
    output logic [TOTAL_WIDTH-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    input  logic [TOTAL_WIDTH-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   busy,
    output logic                   rx_overrun,
    output logic                   tx_underrun,
    output logic                   frame_abort
);

    localparam int               CNT_W    = bit_cnt_width(TOTAL_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL_WIDTH);

    logic                   w_sck_sync, w_sck_rise, w_sck_fall;
    logic                   w_cs_sync, w_cs_rise, w_cs_fall;
    logic                   w_cs_start;
    logic                   w_unused;
    logic                   r_sdo_meta, r_sdo_sync;
    logic [1:0]             r_settle;
    logic                   r_cs_armed;
    spi_state_e             r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [TOTAL_WIDTH-1:0] r_tx_shift, r_rx_shift, r_rx_data;
    logic [TOTAL_WIDTH-1:0] w_fill_word, w_load_word;
    logic                   w_rx_accept;
    logic                   r_rx_valid, r_sdi, r_busy;
    logic                   r_tx_ready, r_tx_underrun, r_rx_overrun, r_frame_abort;

    spi_sync_edge #(.IDLE_VAL(SPI_CPOL)) u_sck_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (sck),
        .o_sync  (w_sck_sync),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    spi_sync_edge #(.IDLE_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (csn[CS_INDEX]),
        .o_sync  (w_cs_sync),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // Other targets' selects and the raw sync levels are intentionally ignored.
    assign w_unused = ^{csn, w_sck_sync, w_cs_rise};

    // sdo runs through the same two-stage depth as sck so a rise strobe pairs
    // with the data bit sampled alongside it. The settle/armed logic stops a
    // csn held low across reset from looking like a fresh falling edge once
    // the reset values flush out of the synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sdo_meta <= 1'b1;
            r_sdo_sync <= 1'b1;
            r_settle   <= 2'd0;
            r_cs_armed <= 1'b0;
        end else begin
            r_sdo_meta <= sdo;
            r_sdo_sync <= r_sdo_meta;
            if (r_settle != 2'd2) begin
                r_settle <= r_settle + 2'd1;
            end
            if (r_settle == 2'd2 && w_cs_sync) begin
                r_cs_armed <= 1'b1;
            end
        end
    end

    assign w_cs_start  = w_cs_fall & r_cs_armed;
    assign w_cnt_next  = r_bit_cnt + CNT_W'(1);
    assign w_rx_accept = (r_state == COMPLETE) && (!r_rx_valid || rx_ready);

`ifdef SPI_TGT_LOOPBACK_EN
    // The word being accepted this cycle counts as the latest one.
    assign w_fill_word = w_rx_accept ? r_rx_shift : r_rx_data;
`else
    assign w_fill_word = TX_IDLE;
`endif

    assign w_load_word = tx_valid ? tx_data : w_fill_word;

    // Frame engine: loads the response word, shifts on synchronized sck
    // edges, hands completed words to the rx holding register and raises
    // the status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_sdi         <= 1'b1;
            r_busy        <= 1'b0;
            r_tx_ready    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_tx_ready    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_frame_abort <= 1'b0;
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_sdi     <= 1'b1;
                    r_bit_cnt <= '0;
                    if (w_cs_start) begin
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_tx_shift    <= w_load_word;
                    r_sdi         <= w_load_word[TOTAL_WIDTH-1];
                    r_bit_cnt     <= '0;
                    r_tx_ready    <= tx_valid;
                    r_tx_underrun <= !tx_valid;
                    r_state       <= SHIFT;
                end
                SHIFT: begin
                    if (w_cs_sync) begin
                        r_frame_abort <= 1'b1;
                        r_sdi         <= 1'b1;
                        r_bit_cnt     <= '0;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end else if (w_sck_rise) begin
                        r_rx_shift <= {r_rx_shift[TOTAL_WIDTH-2:0], r_sdo_sync};
                        r_bit_cnt  <= w_cnt_next;
                        if (w_cnt_next == LAST_CNT) begin
                            r_state <= COMPLETE;
                        end
                    end else if (w_sck_fall && r_bit_cnt != '0) begin
                        // The fall before the first rise is skipped: the MSB
                        // is already on sdi from the load.
                        r_tx_shift <= {r_tx_shift[TOTAL_WIDTH-2:0], 1'b1};
                        r_sdi      <= r_tx_shift[TOTAL_WIDTH-2];
                    end
                end
                COMPLETE: begin
                    if (w_rx_accept) begin
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_rx_overrun <= 1'b1;
                    end
                    if (!w_cs_sync) begin
                        // Back-to-back frame under the same select.
                        r_tx_shift    <= w_load_word;
                        r_sdi         <= w_load_word[TOTAL_WIDTH-1];
                        r_bit_cnt     <= '0;
                        r_tx_ready    <= tx_valid;
                        r_tx_underrun <= !tx_valid;
                        r_state       <= SHIFT;
                    end else begin
                        r_sdi     <= 1'b1;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sdi         = r_sdi;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_ready    = r_tx_ready;
    assign busy        = r_busy;
    assign rx_overrun  = r_rx_overrun;
    assign tx_underrun = r_tx_underrun;
    assign frame_abort = r_frame_abort;

endmodule

// File: tb/tb_spi_target_if.sv
// ---------------------------------------------------------------------------
// tb_spi_target_if
// Directed bench for spi_target_if. An initiator task drives mode-3 frames
// (sck half period HALF clk cycles), a core model drops tx_valid once the
// target reports tx_ready, and a monitor process checks the rx port against
// a queue of expected words and the idle behaviour of sdi/busy every cycle.
// ---------------------------------------------------------------------------
module tb_spi_target_if;

    localparam int W    = 32;
    localparam int HALF = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sck;
    logic          sdo;
    logic [3:0]    csn;
    logic          sdi;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [W-1:0]  tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          rx_overrun;
    logic          tx_underrun;
    logic          frame_abort;

    int testsRun    = 0;
    int testsFailed = 0;
    int txReadyCnt  = 0;
    int underrunCnt = 0;
    int overrunCnt  = 0;
    int abortCnt    = 0;
    int rxWordCnt   = 0;
    int csIdleCnt   = 0;

    logic [W-1:0] expQ[$];
    logic [W-1:0] modelLastRx;

    spi_target_if #(
        .TOTAL_WIDTH (W),
        .CS_INDEX    (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sck         (sck),
        .sdo         (sdo),
        .csn         (csn),
        .sdi         (sdi),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .rx_overrun  (rx_overrun),
        .tx_underrun (tx_underrun),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Word the target must send when the core offers nothing.
    function automatic logic [W-1:0] fillWord();
`ifdef SPI_TGT_LOOPBACK_EN
        return modelLastRx;
`else
        return 32'hFFFF_FFFF;
`endif
    endfunction

    // A frame that will land in the rx holding register.
    task automatic noteAccepted(input logic [W-1:0] word);
        expQ.push_back(word);
        modelLastRx = word;
    endtask

    // Mode-3 initiator: drive on fall, sample sdi on rise, MSB first.
    task automatic applyStimulus(input logic [W-1:0] mosi, input int nBits,
                                 input bit releaseCs, output logic [W-1:0] miso);
        miso = '0;
        for (int i = 0; i < nBits; i++) begin
            @(negedge clk);
            sck = 1'b0;
            sdo = mosi[W-1-i];
            repeat (HALF) @(negedge clk);
            sck  = 1'b1;
            miso = {miso[W-2:0], sdi};
            if (i != nBits - 1) repeat (HALF - 1) @(negedge clk);
        end
        if (releaseCs) begin
            @(negedge clk);
            csn[0] = 1'b1;
        end
    endtask

    task automatic csLow();
        @(negedge clk);
        csn[0] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_sdi"}, sdi, 1);
        checkOutput({tag, "_rx_data"}, rx_data, 0);
        checkOutput({tag, "_rx_valid"}, rx_valid, 0);
        checkOutput({tag, "_tx_ready"}, tx_ready, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_rx_overrun"}, rx_overrun, 0);
        checkOutput({tag, "_tx_underrun"}, tx_underrun, 0);
        checkOutput({tag, "_frame_abort"}, frame_abort, 0);
    endtask

    // Core model on the tx side: a consumed word is withdrawn.
    always @(negedge clk) begin
        if (tx_ready) tx_valid = 1'b0;
    end

    // Monitor: pulse bookkeeping, rx scoreboard, idle sdi/busy.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_ready)    txReadyCnt++;
            if (tx_underrun) underrunCnt++;
            if (rx_overrun)  overrunCnt++;
            if (frame_abort) abortCnt++;
            if (rx_valid && rx_ready) begin
                rxWordCnt++;
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL rx_word: got 0x%0h, expected no word", rx_data);
                end else begin
                    checkOutput("rx_word", rx_data, expQ.pop_front());
                end
            end
            if (csn[0]) csIdleCnt++;
            else        csIdleCnt = 0;
            if (csIdleCnt >= 6) begin
                checkOutput("idle_sdi", sdi, 1);
                checkOutput("idle_busy", busy, 0);
            end
        end else begin
            csIdleCnt = 0;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] miso;
        logic [W-1:0] exp1, exp2;
        int txr0, und0, ovr0, abt0, rxw0;
        int lat;

        rst_n = 1'b0; sck = 1'b1; sdo = 1'b0; csn = 4'hF;
        rx_ready = 1'b1; tx_valid = 1'b0; tx_data = '0; modelLastRx = '0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checkResetValues("post_reset");

        // Single frame with a preloaded response word.
        tx_data = 32'h1234_5678; tx_valid = 1'b1;
        noteAccepted(32'hA5C3_0F1E);
        txr0 = txReadyCnt; und0 = underrunCnt; rxw0 = rxWordCnt;
        csLow();
        applyStimulus(32'hA5C3_0F1E, W, 1'b1, miso);
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            if (rx_valid) lat = c + 1;
        end
        checkOutput("rx_latency_in_window", (lat >= 4 && lat <= 6), 1);
        repeat (10) @(negedge clk);
        checkOutput("single_miso", miso, 32'h1234_5678);
        checkOutput("single_tx_ready", txReadyCnt - txr0, 1);
        checkOutput("single_underrun", underrunCnt - und0, 0);
        checkOutput("single_rx_words", rxWordCnt - rxw0, 1);

        // Two frames under one select, core offers nothing.
        und0 = underrunCnt; rxw0 = rxWordCnt;
        exp1 = fillWord(); noteAccepted(32'h0F0F_0001);
        exp2 = fillWord(); noteAccepted(32'h1357_9BDF);
        csLow();
        applyStimulus(32'h0F0F_0001, W, 1'b0, miso);
        checkOutput("b2b_miso1", miso, exp1);
        repeat (HALF - 1) @(negedge clk);
        applyStimulus(32'h1357_9BDF, W, 1'b1, miso);
        checkOutput("b2b_miso2", miso, exp2);
        repeat (12) @(negedge clk);
        checkOutput("b2b_underrun", underrunCnt - und0, 2);
        checkOutput("b2b_rx_words", rxWordCnt - rxw0, 2);

        // Core stalls rx across two frames.
        rx_ready = 1'b0;
        ovr0 = overrunCnt; rxw0 = rxWordCnt;
        exp1 = fillWord(); noteAccepted(32'h600D_0001);
        csLow();
        applyStimulus(32'h600D_0001, W, 1'b1, miso);
        repeat (12) @(negedge clk);
        checkOutput("stall_miso1", miso, exp1);
        checkOutput("stall_valid1", rx_valid, 1);
        checkOutput("stall_data1", rx_data, 32'h600D_0001);
        exp2 = fillWord();
        csLow();
        applyStimulus(32'h0BAD_0002, W, 1'b1, miso);
        repeat (12) @(negedge clk);
        checkOutput("stall_miso2", miso, exp2);
        checkOutput("stall_overrun", overrunCnt - ovr0, 1);
        checkOutput("stall_data_kept", rx_data, 32'h600D_0001);
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("stall_valid_cleared", rx_valid, 0);
        checkOutput("stall_rx_words", rxWordCnt - rxw0, 1);

        // Select released after 13 bits.
        tx_data = 32'hCAFE_F00D; tx_valid = 1'b1;
        txr0 = txReadyCnt; abt0 = abortCnt; rxw0 = rxWordCnt;
        csLow();
        applyStimulus(32'hFFFF_FFFF, 13, 1'b0, miso);
        repeat (HALF) @(negedge clk);
        csn[0] = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("abort_miso13", miso, 32'h0000_195F);
        checkOutput("abort_pulse", abortCnt - abt0, 1);
        checkOutput("abort_tx_ready", txReadyCnt - txr0, 1);
        checkOutput("abort_rx_words", rxWordCnt - rxw0, 0);
        checkOutput("abort_sdi", sdi, 1);
        checkOutput("abort_busy", busy, 0);
        exp1 = fillWord(); noteAccepted(32'h0000_0001);
        csLow();
        applyStimulus(32'h0000_0001, W, 1'b1, miso);
        repeat (12) @(negedge clk);
        checkOutput("after_abort_miso", miso, exp1);
        checkOutput("after_abort_rx_words", rxWordCnt - rxw0, 1);

        // Reset in the middle of a frame, select held low through it.
        csLow();
        applyStimulus(32'h7777_8888, 20, 1'b0, miso);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("midreset");
        modelLastRx = '0;
        und0 = underrunCnt; txr0 = txReadyCnt;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("midreset_no_restart_busy", busy, 0);
        checkOutput("midreset_no_restart_load", (underrunCnt - und0) + (txReadyCnt - txr0), 0);
        csn[0] = 1'b1;
        repeat (10) @(negedge clk);
        rxw0 = rxWordCnt;
        exp1 = fillWord(); noteAccepted(32'hDEAD_BEEF);
        csLow();
        applyStimulus(32'hDEAD_BEEF, W, 1'b1, miso);
        repeat (12) @(negedge clk);
        checkOutput("post_reset_miso", miso, exp1);
        checkOutput("post_reset_rx_words", rxWordCnt - rxw0, 1);

        // Another target selected: this one must stay silent.
        txr0 = txReadyCnt; und0 = underrunCnt; ovr0 = overrunCnt;
        abt0 = abortCnt; rxw0 = rxWordCnt;
        @(negedge clk);
        csn[1] = 1'b0;
        repeat (6) @(negedge clk);
        applyStimulus(32'h5555_AAAA, W, 1'b0, miso);
        repeat (HALF) @(negedge clk);
        csn[1] = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("other_cs_miso", miso, 32'hFFFF_FFFF);
        checkOutput("other_cs_pulses",
                    (txReadyCnt - txr0) + (underrunCnt - und0) + (overrunCnt - ovr0) + (abortCnt - abt0), 0);
        checkOutput("other_cs_rx_words", rxWordCnt - rxw0, 0);

        checkOutput("rx_queue_drained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
